// File: rtl/bsg_tag_packet_tx.sv
// Serializes parallel bsg_tag requests onto the one-bit tag data/enable pair. Macro BSG_TAG_TX_BOOT_PREAMBLE_EN adds a post-reset flush preamble.
// Latency: start bit on tag_data_o the cycle after the v_i & ready_and_o handshake; packet bits are contiguous.
// Backpressure: ready_and_o is high only in IDLE and does not depend on v_i; the requester holds v_i and the fields until accepted.
module bsg_tag_packet_tx #(
  parameter int els_p        = 64,
  parameter int lg_width_p   = 4,
  parameter int gap_cycles_p = 2,
  localparam int id_width_lp      = (els_p <= 1) ? 1 : $clog2(els_p),
  localparam int payload_width_lp = (1 << lg_width_p) - 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        v_i,
  output logic                        ready_and_o,
  input  logic [id_width_lp-1:0]      client_id_i,
  input  logic                        data_not_reset_i,
  input  logic [lg_width_p-1:0]       len_i,
  input  logic [payload_width_lp-1:0] payload_i,
  output logic                        tag_data_o,
  output logic                        tag_en_o,
  output logic                        busy_o,
  output logic                        done_o
);

  // Header = start bit + client id + data_not_reset + length.
  localparam int hdr_bits_lp    = 2 + id_width_lp + lg_width_p;
  // Everything after the start bit waits in the shift register.
  localparam int sr_width_lp    = hdr_bits_lp - 1 + payload_width_lp;
  localparam int pkt_max_lp     = hdr_bits_lp + payload_width_lp;
  localparam int boot_cycles_lp = (1 << lg_width_p) + id_width_lp + 8;
  localparam int max_a_lp       = ((pkt_max_lp - 1) > gap_cycles_p) ? (pkt_max_lp - 1) : gap_cycles_p;
  localparam int cnt_max_lp     = (max_a_lp > boot_cycles_lp) ? max_a_lp : boot_cycles_lp;
  localparam int cnt_w_lp       = $clog2(cnt_max_lp + 1);
  localparam int gap_load_lp    = (gap_cycles_p > 0) ? (gap_cycles_p - 1) : 0;

  typedef enum logic [1:0] {IDLE, SEND, GAP, BOOT} state_e;

`ifdef BSG_TAG_TX_BOOT_PREAMBLE_EN
  localparam state_e                reset_state_lp = BOOT;
  localparam logic [cnt_w_lp-1:0]   reset_cnt_lp   = cnt_w_lp'(boot_cycles_lp);
`else
  localparam state_e                reset_state_lp = IDLE;
  localparam logic [cnt_w_lp-1:0]   reset_cnt_lp   = '0;
`endif

  state_e                   state_r, state_n;
  logic [cnt_w_lp-1:0]      cnt_r, cnt_n;
  logic [sr_width_lp-1:0]   sr_r, sr_n;
  logic                     tag_data_n, tag_en_n, done_n;
  logic [payload_width_lp-1:0] payload_mask;
  logic [sr_width_lp-1:0]   pkt_load;

  assign ready_and_o = (state_r == IDLE);
  assign busy_o      = (state_r != IDLE);

  // Payload bits at or above len_i are zeroed so they can never reach the wire.
  assign payload_mask = ~({payload_width_lp{1'b1}} << len_i);
  assign pkt_load     = {payload_i & payload_mask, len_i, data_not_reset_i, client_id_i};

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= reset_state_lp;
    else         state_r <= state_n;
  end

  // Next-state: counters reaching zero end SEND, GAP and BOOT.
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      IDLE:    if (v_i) state_n = SEND;
      SEND:    if (cnt_r == '0) state_n = (gap_cycles_p > 0) ? GAP : IDLE;
      GAP:     if (cnt_r == '0) state_n = IDLE;
      BOOT:    if (cnt_r == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output/datapath next values: the counter holds the number of bits still to follow the one on the wire.
  always_comb begin
    cnt_n      = cnt_r;
    sr_n       = sr_r;
    tag_data_n = 1'b0;
    tag_en_n   = 1'b0;
    done_n     = 1'b0;
    unique case (state_r)
      IDLE: begin
        if (v_i) begin
          sr_n       = pkt_load;
          cnt_n      = cnt_w_lp'(hdr_bits_lp - 1) + cnt_w_lp'(len_i);
          tag_data_n = 1'b1;
          tag_en_n   = 1'b1;
        end
      end
      SEND: begin
        if (cnt_r == '0) begin
          done_n = 1'b1;
          cnt_n  = cnt_w_lp'(gap_load_lp);
        end else begin
          tag_data_n = sr_r[0];
          tag_en_n   = 1'b1;
          sr_n       = sr_r >> 1;
          cnt_n      = cnt_r - 1'b1;
        end
      end
      GAP: begin
        if (cnt_r != '0) cnt_n = cnt_r - 1'b1;
      end
      BOOT: begin
        if (cnt_r != '0) begin
          tag_en_n = 1'b1;
          cnt_n    = cnt_r - 1'b1;
        end
      end
      default: cnt_n = '0;
    endcase
  end

  // Datapath and registered tag outputs; reset abandons any in-flight packet.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_r      <= reset_cnt_lp;
      sr_r       <= '0;
      tag_data_o <= 1'b0;
      tag_en_o   <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      cnt_r      <= cnt_n;
      sr_r       <= sr_n;
      tag_data_o <= tag_data_n;
      tag_en_o   <= tag_en_n;
      done_o     <= done_n;
    end
  end

endmodule

// File: tb/tb_bsg_tag_packet_tx.sv
// Bench for bsg_tag_packet_tx: per-cycle comparison against a queue-based packet model,
// plus literal packet values and timing for the directed cases.
module tb_bsg_tag_packet_tx;
  localparam int ID_W   = 6;
  localparam int LG     = 4;
  localparam int PW     = 15;
  localparam int GAP    = 2;
  localparam int BOOT_N = 16 + ID_W + 8;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          v_i = 1'b0;
  logic          ready_and_o;
  logic [ID_W-1:0] client_id_i = '0;
  logic          data_not_reset_i = 1'b0;
  logic [LG-1:0] len_i = '0;
  logic [PW-1:0] payload_i = '0;
  logic          tag_data_o, tag_en_o, busy_o, done_o;

  bsg_tag_packet_tx #(.els_p(64), .lg_width_p(LG), .gap_cycles_p(GAP)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_and_o(ready_and_o),
    .client_id_i(client_id_i), .data_not_reset_i(data_not_reset_i),
    .len_i(len_i), .payload_i(payload_i),
    .tag_data_o(tag_data_o), .tag_en_o(tag_en_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Model: each future cycle is a record; a handshake appends the whole packet plus gap.
  typedef struct packed {logic en; logic data; logic busy; logic last;} rec_t;
  rec_t sched[$];
  rec_t cur = '0;
  logic m_done = 1'b0;
  bit   m_valid = 1'b0;
  bit   pbits[$];

  initial forever begin
    @(posedge clk_i);
    if (reset_i) begin
      sched.delete();
      m_done  = 1'b0;
      m_valid = 1'b1;
`ifdef BSG_TAG_TX_BOOT_PREAMBLE_EN
      cur = '{en:1'b0, data:1'b0, busy:1'b1, last:1'b0};
      for (int i = 0; i < BOOT_N; i++) sched.push_back('{en:1'b1, data:1'b0, busy:1'b1, last:1'b0});
`else
      cur = '0;
`endif
    end else begin
      if (!cur.busy && v_i) begin
        pbits.delete();
        pbits.push_back(1'b1);
        for (int i = 0; i < ID_W; i++) pbits.push_back(client_id_i[i]);
        pbits.push_back(data_not_reset_i);
        for (int i = 0; i < LG; i++) pbits.push_back(len_i[i]);
        for (int i = 0; i < int'(len_i); i++) pbits.push_back(payload_i[i]);
        foreach (pbits[k])
          sched.push_back('{en:1'b1, data:pbits[k], busy:1'b1, last:(k == pbits.size() - 1)});
        for (int i = 0; i < GAP; i++) sched.push_back('{en:1'b0, data:1'b0, busy:1'b1, last:1'b0});
      end
      m_done = cur.last;
      if (sched.size() > 0) cur = sched.pop_front();
      else cur = '0;
    end
  end

  // Compare process plus a log of received packets and enable edges.
  logic [63:0] acc = '0;
  int alen = 0;
  int cyc = 0;
  logic prev_en = 1'b0;
  logic [63:0] pkt_val[$];
  int pkt_len[$];
  int starts[$];
  int ends[$];

  initial forever begin
    @(negedge clk_i);
    if (m_valid) begin
      cyc++;
      chk($sformatf("tag_en@%0d", cyc), tag_en_o, cur.en);
      chk($sformatf("tag_data@%0d", cyc), tag_data_o, cur.data);
      chk($sformatf("busy@%0d", cyc), busy_o, cur.busy);
      chk($sformatf("ready@%0d", cyc), ready_and_o, !cur.busy);
      chk($sformatf("done@%0d", cyc), done_o, m_done);
      if (reset_i) begin
        acc = '0; alen = 0;
      end else begin
        if (tag_en_o) begin acc[alen] = tag_data_o; alen++; end
        if (done_o) begin
          pkt_val.push_back(acc); pkt_len.push_back(alen);
          acc = '0; alen = 0;
        end
      end
      if (tag_en_o && !prev_en) starts.push_back(cyc);
      if (!tag_en_o && prev_en) ends.push_back(cyc - 1);
      prev_en = tag_en_o;
    end
  end

  task automatic clr_log();
    pkt_val.delete(); pkt_len.delete(); starts.delete(); ends.delete();
    acc = '0; alen = 0;
  endtask

  task automatic garble();
    client_id_i      = ID_W'($urandom);
    data_not_reset_i = 1'($urandom);
    len_i            = LG'($urandom);
    payload_i        = PW'($urandom);
  endtask

  // Returns #1 after the handshake edge (the start-bit cycle); fields are scrambled afterwards.
  task automatic send(input logic [ID_W-1:0] id, input logic dnr, input logic [LG-1:0] len,
                      input logic [PW-1:0] pl, input bit scramble_wait);
    int guard = 0;
    v_i = 1'b1;
    while (!ready_and_o && guard < 200) begin
      if (scramble_wait) garble();
      else begin client_id_i = id; data_not_reset_i = dnr; len_i = len; payload_i = pl; end
      @(posedge clk_i); #1;
      guard++;
    end
    if (guard >= 200) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: ready never seen within %0d cycles", guard);
    end
    client_id_i = id; data_not_reset_i = dnr; len_i = len; payload_i = pl;
    @(posedge clk_i); #1;
    garble();
  endtask

  task automatic wait_idle();
    int guard = 0;
    v_i = 1'b0;
    while (!ready_and_o && guard < 200) begin @(posedge clk_i); #1; guard++; end
    if (guard >= 200) begin
      n_chk++; n_fail++;
      $display("FAIL idle_timeout: block still busy after %0d cycles", guard);
    end
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic chk_pkt(input string nm, input int idx, input logic [63:0] v, input int l);
    if (pkt_val.size() <= idx) begin
      n_chk++; n_fail++;
      $display("FAIL %s: packet %0d missing, got %0d packets", nm, idx, pkt_val.size());
    end else begin
      chk({nm, "_val"}, pkt_val[idx][31:0], v[31:0]);
      chk({nm, "_len"}, pkt_len[idx], l);
    end
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    chk("rst_en", tag_en_o, 1'b0);
    chk("rst_data", tag_data_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
`ifdef BSG_TAG_TX_BOOT_PREAMBLE_EN
    chk("rst_busy", busy_o, 1'b1);
    chk("rst_ready", ready_and_o, 1'b0);
    begin
      int n_en = 0;
      int guard = 0;
      @(posedge clk_i); #1;
      while (!ready_and_o && guard < 200) begin
        if (tag_en_o) n_en++;
        @(posedge clk_i); #1;
        guard++;
      end
      chk("boot_en_cycles", n_en, BOOT_N);
    end
`else
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_ready", ready_and_o, 1'b1);
    @(posedge clk_i); #1;
`endif
    clr_log();

    // Single data packet; ready returns 17 cycles after the start-bit cycle.
    send(6'd5, 1'b1, 4'd3, 15'b101, 1'b0);
    v_i = 1'b0;
    lat = 0;
    while (!ready_and_o && lat < 100) begin @(posedge clk_i); #1; lat++; end
    chk("single_ready_lat", lat, 17);
    wait_idle();
    chk_pkt("single", 0, 64'h538B, 15);

    // Client reset packet with garbage payload that must stay off the wire.
    clr_log();
    send(6'd63, 1'b0, 4'd0, 15'h7FFF, 1'b0);
    wait_idle();
    chk_pkt("rstpkt", 0, 64'h07F, 12);

    // Two max-length packets with v_i held high throughout.
    clr_log();
    send(6'd5, 1'b1, 4'd15, 15'h4AAA, 1'b0);
    send(6'd5, 1'b1, 4'd15, 15'h4AAA, 1'b0);
    wait_idle();
    chk_pkt("max0", 0, 64'h4AAAF8B, 27);
    chk_pkt("max1", 1, 64'h4AAAF8B, 27);
    if (starts.size() >= 2 && ends.size() >= 1) chk("b2b_spacing", starts[1] - ends[0], 4);
    else begin
      n_chk++; n_fail++;
      $display("FAIL b2b_spacing: got %0d starts %0d ends, required 2 and 1", starts.size(), ends.size());
    end

    // Reset asserted while bit 6 is on the wire.
    clr_log();
    send(6'd5, 1'b1, 4'd3, 15'b101, 1'b0);
    v_i = 1'b0;
    repeat (6) @(posedge clk_i);
    #1 reset_i = 1'b1;
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    chk("midrst_en", tag_en_o, 1'b0);
    chk("midrst_data", tag_data_o, 1'b0);
    repeat (20) @(posedge clk_i);
    #1;
    wait_idle();
    chk("midrst_nodone", pkt_val.size(), 0);
    clr_log();
    send(6'd5, 1'b1, 4'd3, 15'b101, 1'b0);
    wait_idle();
    chk_pkt("after_rst", 0, 64'h538B, 15);

    // Second request waits with scrambled fields while the first is in flight.
    clr_log();
    send(6'd9, 1'b1, 4'd4, 15'h000B, 1'b0);
    send(6'd42, 1'b0, 4'd2, 15'h7FFF, 1'b1);
    wait_idle();
    chk_pkt("stallA", 0, 64'hB493, 16);
    chk_pkt("stallB", 1, 64'h3255, 14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
